// File: rtl/w_update_seq.sv
// Time-multiplexed LMS weight-update sequencer for the linear section of the spline filter.
// A single multiplier/rounder/adder walks the tap buffer and applies w[k] += round(x[k]*mu).
module w_update_seq #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned QP        = 12,
  parameter int unsigned N_TAPS    = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter int          RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  mu_error_i,
  input  logic              clear_w_i,
  output logic              x_rd_en_o,
  output logic [ADDR_W-1:0] x_rd_addr_o,
  input  logic [WIDTH-1:0]  x_rd_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  input  logic [ADDR_W-1:0] w_rd_addr_i,
  output logic [WIDTH-1:0]  w_rd_data_o
);

  localparam logic [WIDTH-1:0]   WRst     = WIDTH'(RESET_VAL <<< QP);
  localparam logic [ADDR_W-1:0]  LastAddr = ADDR_W'(N_TAPS - 1);
  localparam logic [2*WIDTH-1:0] Half     = {{(2*WIDTH-1){1'b0}}, 1'b1} << (QP - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic              drain_q, drain_d;
  logic              x_rd_en_q, x_rd_en_d;
  logic [ADDR_W-1:0] x_rd_addr_q, x_rd_addr_d;
  logic [WIDTH-1:0]  mu_q, mu_d;
  logic              done_q, done_d;
  logic              clear_all;

  // Read-return stage and write stage of the shared datapath
  logic              rd_v_q, wr_v_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [WIDTH-1:0]  delta_q;

  logic [WIDTH-1:0]  w_q [N_TAPS];

  logic signed [2*WIDTH-1:0] prod;
  logic        [2*WIDTH-1:0] rnd;
  logic        [WIDTH-1:0]   delta;
  logic                      unused_rnd;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    x_rd_en_d   = 1'b0;
    x_rd_addr_d = x_rd_addr_q;
    mu_d        = mu_q;
    done_d      = 1'b0;
    clear_all   = 1'b0;
    case (state_q)
      StIdle: begin
        // Clear takes priority over start; the start is dropped silently.
        if (clear_w_i) begin
          clear_all = 1'b1;
        end else if (start_i) begin
          state_d     = StIssue;
          x_rd_en_d   = 1'b1;
          x_rd_addr_d = '0;
          mu_d        = mu_error_i;
        end
      end
      StIssue: begin
        if (x_rd_addr_q == LastAddr) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end else begin
          x_rd_en_d   = 1'b1;
          x_rd_addr_d = x_rd_addr_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      drain_q     <= 1'b0;
      x_rd_en_q   <= 1'b0;
      x_rd_addr_q <= '0;
      mu_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      x_rd_en_q   <= x_rd_en_d;
      x_rd_addr_q <= x_rd_addr_d;
      mu_q        <= mu_d;
      done_q      <= done_d;
    end
  end

  assign prod       = $signed(x_rd_data_i) * $signed(mu_q);
  assign rnd        = prod + Half;
  assign delta      = rnd[QP +: WIDTH];
  assign unused_rnd = ^{rnd[2*WIDTH-1:QP+WIDTH], rnd[QP-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_v_q    <= 1'b0;
      wr_addr_q <= '0;
      delta_q   <= '0;
    end else begin
      rd_v_q    <= x_rd_en_q;
      rd_addr_q <= x_rd_addr_q;
      wr_v_q    <= rd_v_q;
      wr_addr_q <= rd_addr_q;
      delta_q   <= rd_v_q ? delta : delta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      for (int i = 0; i < int'(N_TAPS); i++) begin
        w_q[i] <= WRst;
      end
    end else if (wr_v_q) begin
      w_q[wr_addr_q] <= w_q[wr_addr_q] + delta_q;
    end
  end

  always_comb begin
    w_rd_data_o = '0;
    if ({{(32-ADDR_W){1'b0}}, w_rd_addr_i} < N_TAPS) begin
      w_rd_data_o = w_q[w_rd_addr_i];
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign overrun_o   = start_i && busy_o && !reset;
  assign done_o      = done_q;
  assign x_rd_en_o   = x_rd_en_q;
  assign x_rd_addr_o = x_rd_addr_q;

endmodule

// File: tb/tb_w_update_seq.sv
// Self-checking bench for w_update_seq: directed scenarios plus random rounds against a
// per-tap arithmetic reference model.
module tb_w_update_seq;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        clear_w = 1'b0;
  logic [15:0] mu_error = '0;
  logic [15:0] x_rd_data = '0;
  logic        x_rd_en;
  logic [1:0]  x_rd_addr;
  logic [1:0]  w_rd_addr = '0;
  logic        busy, done, overrun;
  logic [15:0] w_rd_data;

  int checks = 0;
  int failures = 0;

  logic [15:0] xmem [N];
  logic [15:0] wm   [N];

  w_update_seq #(
    .WIDTH(16), .QP(12), .N_TAPS(N), .ADDR_W(2), .RESET_VAL(0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .mu_error_i  (mu_error),
    .clear_w_i   (clear_w),
    .x_rd_en_o   (x_rd_en),
    .x_rd_addr_o (x_rd_addr),
    .x_rd_data_i (x_rd_data),
    .busy_o      (busy),
    .done_o      (done),
    .overrun_o   (overrun),
    .w_rd_addr_i (w_rd_addr),
    .w_rd_data_o (w_rd_data)
  );

  always #5 clk = ~clk;

  // Tap-delay buffer: data returns one cycle after the read strobe
  always @(posedge clk) if (x_rd_en) x_rd_data <= xmem[x_rd_addr];

  function automatic logic [15:0] delta_of(input logic [15:0] x, input logic [15:0] mu);
    longint p;
    p = longint'($signed(x)) * longint'($signed(mu)) + 64'sd2048;
    return 16'(p >>> 12);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int k, input logic [15:0] exp, input string tag);
    w_rd_addr = 2'(k);
    #1;
    chk(tag, {16'h0, w_rd_data}, {16'h0, exp});
  endtask

  task automatic check_weights(input string tag);
    for (int k = 0; k < N; k++) rd(k, wm[k], tag);
    w_rd_addr = '0;
  endtask

  task automatic do_clear();
    clear_w = 1'b1;
    tick();
    clear_w = 1'b0;
    for (int k = 0; k < N; k++) wm[k] = '0;
  endtask

  // Issues start in the current cycle S and follows the round to its done cycle.
  task automatic do_round(input logic [15:0] mu, input bit mid_start);
    logic [15:0] old0;
    logic [15:0] newv [N];
    old0 = wm[0];
    for (int k = 0; k < N; k++) newv[k] = wm[k] + delta_of(xmem[k], mu);
    w_rd_addr = '0;
    start = 1'b1;
    mu_error = mu;
    #1;
    chk("overrun_at_accept", {31'b0, overrun}, 0);
    for (int c = 1; c <= N + 3; c++) begin
      tick();
      start = mid_start && (c == 2);
      mu_error = 16'($urandom);
      #1;
      chk("x_rd_en", {31'b0, x_rd_en}, {31'b0, c <= N});
      chk("x_rd_addr", {30'b0, x_rd_addr}, (c <= N) ? c - 1 : N - 1);
      chk("busy", {31'b0, busy}, {31'b0, c <= N + 2});
      chk("done", {31'b0, done}, {31'b0, c == N + 3});
      chk("overrun", {31'b0, overrun}, {31'b0, mid_start && c == 2});
      chk("w0_collision", {16'h0, w_rd_data}, {16'h0, (c >= 4) ? newv[0] : old0});
    end
    start = 1'b0;
    for (int k = 0; k < N; k++) wm[k] = newv[k];
    check_weights("w_after_round");
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      xmem[k] = '0;
      wm[k] = '0;
    end

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_x_rd_en", {31'b0, x_rd_en}, 0);
    chk("rst_x_rd_addr", {30'b0, x_rd_addr}, 0);
    check_weights("rst_weight");

    // Half-step update, twice
    for (int k = 0; k < N; k++) xmem[k] = 16'h1000;
    tick();
    do_round(16'h0800, 1'b0);
    rd(1, 16'h0800, "half_step");
    tick();
    do_round(16'h0800, 1'b0);
    rd(3, 16'h1000, "two_half_steps");

    // Rounding boundaries
    tick();
    do_clear();
    xmem[0] = 16'h0800; xmem[1] = 16'h07FF; xmem[2] = 16'hFFFF; xmem[3] = 16'hF800;
    do_round(16'h0001, 1'b0);
    rd(0, 16'h0001, "round_half_up");
    rd(1, 16'h0000, "round_below_half");
    rd(3, 16'h0000, "round_neg_half");
    tick();
    do_clear();
    for (int k = 0; k < N; k++) xmem[k] = 16'h0801;
    do_round(16'hFFFF, 1'b0);
    rd(2, 16'hFFFF, "round_minus_one");

    // Wrap from max positive to min negative
    tick();
    do_clear();
    xmem[0] = '0; xmem[1] = '0; xmem[2] = 16'h1000; xmem[3] = '0;
    do_round(16'h7FFF, 1'b0);
    rd(2, 16'h7FFF, "preload_max");
    tick();
    xmem[0] = 16'($urandom); xmem[1] = 16'($urandom); xmem[3] = 16'($urandom);
    do_round(16'h0001, 1'b0);
    rd(2, 16'h8000, "wrap");

    // Random rounds, one with a start while busy, then back-to-back rounds
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N; k++) xmem[k] = 16'($urandom);
      tick();
      do_round(16'($urandom), i == 1);
    end
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < N; k++) xmem[k] = 16'($urandom);
      do_round(16'($urandom), 1'b0);
    end

    // Reset in the middle of a round
    for (int k = 0; k < N; k++) xmem[k] = 16'($urandom);
    tick();
    start = 1'b1;
    mu_error = 16'h4321;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_x_rd_en", {31'b0, x_rd_en}, 0);
    for (int k = 0; k < N; k++) wm[k] = '0;
    check_weights("abort_weight");
    for (int i = 0; i < N + 4; i++) begin
      tick();
      chk("abort_no_done", {31'b0, done}, 0);
    end

    // Clear with start in idle
    for (int k = 0; k < N; k++) xmem[k] = 16'h1000;
    do_round(16'h0400, 1'b0);
    tick();
    clear_w = 1'b1;
    start = 1'b1;
    #1;
    chk("clear_start_overrun", {31'b0, overrun}, 0);
    tick();
    clear_w = 1'b0;
    start = 1'b0;
    #1;
    chk("clear_start_busy", {31'b0, busy}, 0);
    chk("clear_start_x_rd_en", {31'b0, x_rd_en}, 0);
    for (int k = 0; k < N; k++) wm[k] = '0;
    check_weights("clear_weight");
    for (int i = 0; i < N + 4; i++) begin
      tick();
      chk("clear_no_done", {31'b0, done}, 0);
      chk("clear_no_busy", {31'b0, busy}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w_update_seq.md
Name: w_update_seq

Overview:
- Time-multiplexed weight-update sequencer for the spline adaptive filter's linear (Wiener) section.
- Owns a bank of N_TAPS signed fixed-point weights and shares one multiplier/rounder/adder across them.
- Each update round reads the input tap-delay buffer one sample per cycle and applies w[k] += round(x[k]·mu_error).
- Sits between the error/step-size computation (which issues start) and the FIR datapath (which reads weights through the read port).

Parameters:
- WIDTH, 16, data and weight word width, signed two's complement.
- QP, 12, fractional bits; 1.0 = 1<<QP.
- N_TAPS, 4, number of weights; must be ≥2.
- ADDR_W, 2, tap address width; must satisfy 2^ADDR_W ≥ N_TAPS.
- RESET_VAL, 0, integer reset value of every weight; the stored value is RESET_VAL<<<QP.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request an update round; sampled only when busy=0.
- mu_error  in  WIDTH  step-size-scaled error, signed Q(WIDTH-QP).QP; latched on start acceptance.
- clear_w  in  1  reload all weights with RESET_VAL<<<QP; honoured only when busy=0.
- x_rd_en  out  1  tap-buffer read strobe.
- x_rd_addr  out  ADDR_W  tap index k.
- x_rd_data  in  WIDTH  x[k]; valid exactly one cycle after the matching x_rd_en.
- busy  out  1  round in progress.
- done  out  1  one-cycle pulse when the round's last weight is visible.
- overrun  out  1  one-cycle pulse when start arrives while busy=1.
- w_rd_addr  in  ADDR_W  FIR-side weight index.
- w_rd_data  out  WIDTH  combinational read of weight[w_rd_addr]; returns 0 if the address is ≥N_TAPS.

Behaviour:
- Reset: all weights = RESET_VAL<<<QP; FSM=IDLE; busy, done, overrun, x_rd_en = 0; x_rd_addr = 0; latched mu = 0; pipeline registers cleared. Reset overrides everything, including a round in progress; a partially updated round is abandoned and no done is produced.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE → ISSUE on start=1 with clear_w=0.
  - ISSUE: counter k = 0..N_TAPS-1; on k=N_TAPS-1 go to DRAIN.
  - DRAIN lasts 2 cycles, then IDLE.
- Timing (S = cycle in which start is accepted):
  - x_rd_en=1 and x_rd_addr=k in cycle S+1+k.
  - x_rd_data for tap k is sampled in cycle S+2+k.
  - The rounded product is registered at the end of S+2+k.
  - weight[k] is written at the end of S+3+k.
- busy = 1 in cycles S+1 .. S+N_TAPS+2.
- done = 1 in cycle S+N_TAPS+3; busy=0 in that same cycle. Round latency is N_TAPS+3 cycles.
- Back-to-back rounds: start in the done cycle is accepted.
- Arithmetic, per tap:
  - p = x·mu, full 2·WIDTH signed product.
  - r = p + (1<<(QP-1)), round-half-up.
  - delta = r[QP +: WIDTH].
  - weight[k] ← weight[k] + delta, modulo 2^WIDTH (wrap, no saturation).
- mu_error changes during a round have no effect on that round.
- start while busy=1: ignored; overrun pulses for 1 cycle. The round in progress is unaffected.
- clear_w while busy=1: ignored, no flag.
- clear_w and start both high in IDLE: clear wins; start is dropped; no round runs; no done; no overrun.
- Read/write collision: w_rd_data shows the old weight until the write edge, then the new value.
- x_rd_en=0 and x_rd_addr holds its last value outside ISSUE.

Test Plan:
- Reset, then read all taps → every w_rd_data = 0x0000 (RESET_VAL=0); busy=0, done=0.
- x[k]=0x1000 for all k, mu=0x0800, start in cycle S → x_rd_en high S+1..S+4; done in S+7; all weights = 0x0800; second identical round → 0x1000.
- Rounding: mu=0x0001 with x={0x0800, 0x07FF, 0xFFFF, 0xF800} → deltas {1, 0, 0, 0}; mu=0xFFFF with x=0x0801 → delta -1 (0xFFFF).
- Wrap: preload weight[2]=0x7FFF via a prior round; apply delta=+1 → weight[2]=0x8000; other taps are changed only by their own deltas.
- start pulsed in S+2 of a running round → overrun=1 for one cycle; done still at S+7 with unchanged results; start in the done cycle → new round begins, x_rd_en at done+1.
- Assert reset in S+3 → immediately idle, all weights 0, no done. Separately, clear_w with start in IDLE → weights reset, no round, no done.
